// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side constants and the fetch queue entry type.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched words; flush empties it in one cycle.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;

    logic            w_wr;
    logic            w_rd;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_head];

    // A full queue may still accept a word when the head leaves in the same cycle.
    assign w_wr = push & ~flush & (~full | pop);
    assign w_rd = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_tail] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_rd) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, and queues words
// for decode; execute redirects flush the queue and retarget the PC.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 2,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
)(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(QDEPTH);

    logic [31:0]   r_pc;
    logic          r_fault;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    fetch_entry_t  w_din;
    fetch_entry_t  w_dout;

    assign imem_addr   = r_pc;
    assign fetch_fault = r_fault;

    assign out_valid = (w_count != '0);
    assign out_instr = w_empty ? NOP_INSTR : w_dout.instr;
    assign out_pc    = w_empty ? 32'h0     : w_dout.pc;

    assign w_pop  = out_valid & out_ready;
    assign w_push = ~rst & ~redirect_valid & ~r_fault & (~w_full | w_pop);

    assign w_din.instr = imem_instr;
    assign w_din.pc    = r_pc;

    // A misaligned target parks the PC until an aligned redirect arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_fault <= |redirect_pc[1:0];
        end else if (w_push) begin
            r_pc    <= r_pc + PC_STEP;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed checks of instruction_fetch against a queue model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          QD  = 2;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_fault;
    bit          m_known = 0;

    instruction_fetch #(
        .RESET_PC  (32'h0),
        .QDEPTH    (QD),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_0093;
            32'h8:   return 32'h0040_0093;
            32'hC:   return 32'hFF5F_F06F;
            default: return NOP;
        endcase
    endfunction

    assign imem_instr = mem_rd(imem_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance it.
    task automatic step(input logic r, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        bit v;
        bit pop;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        v = (m_q.size() != 0);
        if (m_known) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, v});
            check("out_instr", out_instr, v ? m_q[0].instr : NOP);
            check("out_pc",    out_pc,    v ? m_q[0].pc : 32'h0);
            check("imem_addr", imem_addr, m_pc);
            check("fault",     {31'b0, fetch_fault}, {31'b0, m_fault});
        end
        pop = v && rdy;
        if (r) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_known = 1;
        end else if (rv) begin
            m_q.delete();
            m_pc    = rpc;
            m_fault = (rpc % 4) != 0;
        end else begin
            bit room;
            room = (m_q.size() < QD) || pop;
            if (pop) void'(m_q.pop_front());
            if (!m_fault && room) begin
                m_q.push_back('{instr: mem_rd(m_pc), pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_instr", out_instr, NOP);
        check("rst_addr",  imem_addr, 32'h0);
        step(0, 0, 0, 1);
        check("first_pc",    out_pc,    32'h0);
        check("first_instr", out_instr, 32'h0010_0093);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("seq_pc",    out_pc,    32'h14);

        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("stall_addr", imem_addr, 32'h8);
        check("stall_pc",   out_pc,    32'h0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("head8_pc", out_pc, 32'h8);
        step(0, 1, 32'h0, 0);
        step(0, 0, 0, 1);
        check("redir_empty", {31'b0, out_valid}, 32'h0);
        step(0, 0, 0, 1);
        check("redir_pc",    out_pc,    32'h0);
        check("redir_instr", out_instr, 32'h0010_0093);

        step(0, 1, 32'h6, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("mis_fault", {31'b0, fetch_fault}, 32'h1);
        check("mis_addr",  imem_addr, 32'h6);
        step(0, 1, 32'h4, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("realign_pc",    out_pc,    32'h4);
        check("realign_instr", out_instr, 32'h0020_0093);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 32'h40, 0);
        step(0, 0, 0, 1);
        check("rst_over_redir", imem_addr, 32'h0);

        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wrap_pc1",    out_pc,    32'h0);
        check("wrap_instr1", out_instr, 32'h0010_0093);

        for (int i = 0; i < 600; i++) begin
            logic r;
            logic rv;
            r  = ($urandom_range(0, 49) == 0);
            rv = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: tgt = 32'(($urandom_range(0, 7)) * 4);
                1: tgt = 32'($urandom_range(0, 31)) | 32'h1;
                2: tgt = 32'hFFFF_FFF8;
                default: tgt = 32'(($urandom_range(0, 3)) * 4 + 2);
            endcase
            step(r, rv, tgt, ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
